// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port data memory.
// The arbiter sits on the slave modport; the requesters and memory model drive the master side.
interface dmem_arbiter_if #(
  parameter int AW = 10
);
  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [3:0]    core_mask;
  logic [31:0]   core_wdata;
  logic          core_stall;
  logic [31:0]   core_rdata;
  logic          core_rvalid;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [3:0]    dma_mask;
  logic [31:0]   dma_wdata;
  logic          dma_gnt;
  logic [31:0]   dma_rdata;
  logic          dma_rvalid;

  logic          mem_ceb;
  logic          mem_web;
  logic [AW-1:0] mem_a;
  logic [3:0]    mem_mask;
  logic [31:0]   mem_d;
  logic [31:0]   mem_q;

  modport slave (
    input  core_req, core_we, core_addr, core_mask, core_wdata,
    output core_stall, core_rdata, core_rvalid,
    input  dma_req, dma_we, dma_addr, dma_mask, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid,
    output mem_ceb, mem_web, mem_a, mem_mask, mem_d,
    input  mem_q
  );

  modport master (
    output core_req, core_we, core_addr, core_mask, core_wdata,
    input  core_stall, core_rdata, core_rvalid,
    output dma_req, dma_we, dma_addr, dma_mask, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  mem_ceb, mem_web, mem_a, mem_mask, mem_d,
    output mem_q
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Core/DMA arbiter for the single-port synchronous-read data memory.
// Core has fixed priority; a saturating wait counter forces one DMA grant after MAX_WAIT denials.
module dmem_arbiter #(
  parameter int AW       = 10,
  parameter int MAX_WAIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  logic [CW-1:0] wait_cnt;
  logic          rd_core;
  logic          rd_dma;
  logic          wait_full;
  logic          gnt_core;
  logic          gnt_dma;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [3:0]    sel_mask;
  logic [31:0]   sel_wdata;

  assign wait_full = (wait_cnt == WAIT_MAX);

  // Reset masks all grants so the memory sees idle while rst is high.
  always_comb begin
    gnt_core = 1'b0;
    gnt_dma  = 1'b0;
    if (!rst) begin
      if (bus.core_req && !(bus.dma_req && wait_full)) begin
        gnt_core = 1'b1;
      end else if (bus.dma_req) begin
        gnt_dma = 1'b1;
      end
    end
  end

  assign bus.core_stall = bus.core_req && !gnt_core && !rst;
  assign bus.dma_gnt    = gnt_dma;

  always_comb begin
    sel_we    = bus.core_we;
    sel_addr  = bus.core_addr;
    sel_mask  = bus.core_mask;
    sel_wdata = bus.core_wdata;
    if (gnt_dma) begin
      sel_we    = bus.dma_we;
      sel_addr  = bus.dma_addr;
      sel_mask  = bus.dma_mask;
      sel_wdata = bus.dma_wdata;
    end
  end

  // A zero-mask write is served (granted) but never reaches the memory.
  always_comb begin
    bus.mem_ceb  = 1'b1;
    bus.mem_web  = 1'b1;
    bus.mem_a    = '0;
    bus.mem_mask = 4'b0000;
    bus.mem_d    = 32'h0;
    if (gnt_core || gnt_dma) begin
      if (!sel_we) begin
        bus.mem_ceb = 1'b0;
        bus.mem_a   = sel_addr;
      end else if (sel_mask != 4'b0000) begin
        bus.mem_ceb  = 1'b0;
        bus.mem_web  = 1'b0;
        bus.mem_a    = sel_addr;
        bus.mem_mask = sel_mask;
        bus.mem_d    = sel_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      rd_core  <= 1'b0;
      rd_dma   <= 1'b0;
    end else begin
      rd_core <= gnt_core && !bus.core_we;
      rd_dma  <= gnt_dma && !bus.dma_we;
      if (gnt_dma) begin
        wait_cnt <= '0;
      end else if (bus.dma_req && !wait_full) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  // Gating with rst drops a response whose read was granted just before reset.
  assign bus.core_rvalid = rd_core && !rst;
  assign bus.dma_rvalid  = rd_dma && !rst;
  assign bus.core_rdata  = bus.core_rvalid ? bus.mem_q : 32'h0;
  assign bus.dma_rdata   = bus.dma_rvalid ? bus.mem_q : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural synchronous-read memory.
// Expected read responses are queued with their due cycle and matched by a response monitor.
module tb_dmem_arbiter;

  localparam int AW = 10;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  rsp_t exp_core[$];
  rsp_t exp_dma[$];

  logic [31:0] mem [0:(1<<AW)-1];

  dmem_arbiter_if #(.AW(AW)) bus ();

  dmem_arbiter #(.AW(AW), .MAX_WAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!bus.mem_ceb) begin
      if (!bus.mem_web) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_mask[b]) mem[bus.mem_a][8*b +: 8] <= bus.mem_d[8*b +: 8];
      end else begin
        bus.mem_q <= mem[bus.mem_a];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    rsp_t e;
    if (bus.core_rvalid) begin
      if (exp_core.size() == 0) chk("core_unexpected_rvalid", 1, 0);
      else begin
        e = exp_core.pop_front();
        chk("core_rdata", bus.core_rdata, e.data);
        chk("core_rsp_cycle", cyc, e.cyc);
      end
      if (!bus.dma_rvalid) chk("dma_rdata_nonowner", bus.dma_rdata, 0);
    end else if (exp_core.size() > 0 && exp_core[0].cyc <= cyc) begin
      chk("core_rvalid_missing", 0, 1);
      void'(exp_core.pop_front());
    end
    if (bus.dma_rvalid) begin
      if (exp_dma.size() == 0) chk("dma_unexpected_rvalid", 1, 0);
      else begin
        e = exp_dma.pop_front();
        chk("dma_rdata", bus.dma_rdata, e.data);
        chk("dma_rsp_cycle", cyc, e.cyc);
      end
      if (!bus.core_rvalid) chk("core_rdata_nonowner", bus.core_rdata, 0);
    end else if (exp_dma.size() > 0 && exp_dma[0].cyc <= cyc) begin
      chk("dma_rvalid_missing", 0, 1);
      void'(exp_dma.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = '0;
    bus.core_mask = 4'h0; bus.core_wdata = 32'h0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0;
    bus.dma_mask = 4'h0; bus.dma_wdata = 32'h0;
  endtask

  task automatic push_core(input logic [31:0] d);
    rsp_t e;
    e.data = d; e.cyc = cyc + 1;
    exp_core.push_back(e);
  endtask

  task automatic push_dma(input logic [31:0] d);
    rsp_t e;
    e.data = d; e.cyc = cyc + 1;
    exp_dma.push_back(e);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_core_rvalid"}, bus.core_rvalid, 0);
    chk({tag, "_dma_rvalid"}, bus.dma_rvalid, 0);
    chk({tag, "_core_rdata"}, bus.core_rdata, 0);
    chk({tag, "_dma_rdata"}, bus.dma_rdata, 0);
    chk({tag, "_dma_gnt"}, bus.dma_gnt, 0);
    chk({tag, "_core_stall"}, bus.core_stall, 0);
    chk({tag, "_mem_ceb"}, bus.mem_ceb, 1);
    chk({tag, "_mem_web"}, bus.mem_web, 1);
    chk({tag, "_mem_a"}, 32'(bus.mem_a), 0);
    chk({tag, "_mem_mask"}, 32'(bus.mem_mask), 0);
    chk({tag, "_mem_d"}, bus.mem_d, 0);
  endtask

  task automatic contend(input int n, input int force_at, input int drop_last);
    bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 10'd1;
    bus.dma_req  = 1'b1; bus.dma_we  = 1'b0; bus.dma_addr  = 10'd2;
    for (int i = 0; i < n; i++) begin
      logic forced;
      forced = ((i % force_at) == force_at - 1);
      if (!(drop_last != 0 && i == n - 1)) begin
        if (forced) push_dma(32'h22);
        else push_core(32'h11);
      end
      @(negedge clk);
      chk("cont_dma_gnt", bus.dma_gnt, forced);
      chk("cont_core_stall", bus.core_stall, forced);
      chk("cont_mem_a", 32'(bus.mem_a), forced ? 2 : 1);
      step();
    end
  endtask

  initial begin
    bus.mem_q = 32'h0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
    mem[1] = 32'h11;
    mem[2] = 32'h22;
    idle();
    bus.core_req = 1'b1; bus.dma_req = 1'b1;
    rst = 1'b1;
    step();
    @(negedge clk);
    chk_reset_outputs("rst0");
    step();
    rst = 1'b0;
    idle();
    step();

    // core write then read
    bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 10'd5;
    bus.core_mask = 4'hF; bus.core_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("cw_stall", bus.core_stall, 0);
    chk("cw_ceb", bus.mem_ceb, 0);
    chk("cw_web", bus.mem_web, 0);
    chk("cw_a", 32'(bus.mem_a), 5);
    chk("cw_mask", 32'(bus.mem_mask), 32'hF);
    chk("cw_d", bus.mem_d, 32'hDEADBEEF);
    step();
    bus.core_we = 1'b0; bus.core_mask = 4'h0; bus.core_wdata = 32'h0;
    push_core(32'hDEADBEEF);
    @(negedge clk);
    chk("cr_stall", bus.core_stall, 0);
    chk("cr_web", bus.mem_web, 1);
    chk("cr_mask", 32'(bus.mem_mask), 0);
    step();
    idle();
    step();

    // DMA byte write, then DMA read of the merged word
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 10'd3;
    bus.dma_mask = 4'b0100; bus.dma_wdata = 32'h00AB0000;
    @(negedge clk);
    chk("dw_gnt", bus.dma_gnt, 1);
    chk("dw_mask", 32'(bus.mem_mask), 32'h4);
    chk("dw_web", bus.mem_web, 0);
    chk("dw_ceb", bus.mem_ceb, 0);
    step();
    bus.dma_we = 1'b0; bus.dma_mask = 4'h0; bus.dma_wdata = 32'h0;
    push_dma(32'h00AB0000);
    @(negedge clk);
    chk("dr_gnt", bus.dma_gnt, 1);
    step();
    idle();
    step();

    // alternating owners, back to back
    bus.core_req = 1'b1; bus.core_addr = 10'd1;
    push_core(32'h11);
    step();
    idle();
    bus.dma_req = 1'b1; bus.dma_addr = 10'd2;
    push_dma(32'h22);
    @(negedge clk);
    chk("alt_dma_gnt", bus.dma_gnt, 1);
    step();
    bus.dma_req = 1'b0;
    bus.core_req = 1'b1; bus.core_addr = 10'd5;
    push_core(32'hDEADBEEF);
    step();
    idle();
    step();

    // zero-mask write must not disturb addr 5
    bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 10'd5;
    bus.core_mask = 4'h0; bus.core_wdata = 32'h12345678;
    @(negedge clk);
    chk("mz_ceb", bus.mem_ceb, 1);
    chk("mz_stall", bus.core_stall, 0);
    step();
    bus.core_we = 1'b0; bus.core_wdata = 32'h0;
    push_core(32'hDEADBEEF);
    step();
    idle();
    step();

    // full contention, period 5
    contend(15, 5, 0);
    idle();
    step();

    // partial contention, then reset drops the outstanding core read and clears wait_cnt
    contend(3, 5, 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("rst1");
    step();
    rst = 1'b0;
    contend(5, 5, 0);
    idle();
    step();

    // reset in the cycle after a granted DMA read
    bus.dma_req = 1'b1; bus.dma_addr = 10'd2;
    @(negedge clk);
    chk("rd_pre_rst_gnt", bus.dma_gnt, 1);
    step();
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("rst2");
    step();
    rst = 1'b0;
    contend(5, 5, 0);
    idle();
    repeat (3) step();

    chk("core_queue_drained", exp_core.size(), 0);
    chk("dma_queue_drained", exp_dma.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
